// File: rtl/ldpc_encoder.sv
// ldpc_encoder: systematic (15,5) LDPC encoder, one message bit folded into parity per cycle,
// codeword presented with an optional error mask over a valid/ready handshake.
module ldpc_encoder #(
    parameter logic [0:9] G0 = 10'b1100100110,
    parameter logic [0:9] G1 = 10'b0110010011,
    parameter logic [0:9] G2 = 10'b1011001001,
    parameter logic [0:9] G3 = 10'b0101100101,
    parameter logic [0:9] G4 = 10'b1010110010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:4]  msg,
    input  logic [0:14] err_mask,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [0:14] y_t,
    output logic        y_valid,
    input  logic        y_ready,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [0:9]  par_q, par_d, g_sel;
    logic [0:4]  msg_q, msg_d;
    logic [0:14] mask_q, mask_d, y_q, y_d;
    logic        yv_q, yv_d, rdy_q, rdy_d, busy_q, busy_d, bit_sel;

    always_comb begin
        g_sel = cnt_q == 3'd0 ? G0 : cnt_q == 3'd1 ? G1 : cnt_q == 3'd2 ? G2 : cnt_q == 3'd3 ? G3 : G4;
        bit_sel = cnt_q == 3'd0 ? msg_q[0] : cnt_q == 3'd1 ? msg_q[1] : cnt_q == 3'd2 ? msg_q[2] :
                  cnt_q == 3'd3 ? msg_q[3] : msg_q[4];
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        msg_d   = msg_q;
        mask_d  = mask_q;
        y_d     = y_q;
        yv_d    = yv_q;
        if (state_q == IDLE && msg_valid) begin
            msg_d   = msg;
            mask_d  = err_mask;
            par_d   = '0;
            cnt_d   = '0;
            state_d = ACC;
        end else if (state_q == ACC) begin
            par_d = par_q ^ (bit_sel ? g_sel : 10'b0);
            cnt_d = cnt_q + 3'd1;
            // last message bit: the codeword uses this cycle's parity, not the registered one
            if (cnt_q == 3'd4) begin
                cnt_d   = '0;
                y_d     = {msg_q, par_d} ^ mask_q;
                yv_d    = 1'b1;
                state_d = OUT;
            end
        end else if (state_q == OUT && y_ready) begin
            yv_d    = 1'b0;
            state_d = IDLE;
        end
        rdy_d  = state_d == IDLE;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= '0;
            msg_q   <= '0;
            mask_q  <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            msg_q   <= msg_d;
            mask_q  <= mask_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign msg_ready = rdy_q;
    assign y_t       = y_q;
    assign y_valid   = yv_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_ldpc_encoder.sv
// tb_ldpc_encoder: directed scoreboard bench for ldpc_encoder; a monitor pops expected
// codewords on every output handshake and also checks the syndrome of unmasked codewords.
module tb_ldpc_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:4]  msg = '0;
    logic [0:14] err_mask = '0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [0:14] y_t;
    logic        y_valid;
    logic        y_ready = 1'b1;
    logic        busy;

    typedef struct {
        logic [0:14] cw;
        bit          syn;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    int          n_exp = 0;
    logic [0:9]  gt[5] = '{10'b1100100110, 10'b0110010011, 10'b1011001001, 10'b0101100101, 10'b1010110010};

    ldpc_encoder dut (
        .clk(clk), .reset(reset), .msg(msg), .err_mask(err_mask), .msg_valid(msg_valid),
        .msg_ready(msg_ready), .y_t(y_t), .y_valid(y_valid), .y_ready(y_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [0:14] enc(input logic [0:4] m);
        logic [0:9] p = '0;
        for (int i = 0; i < 5; i++) if (m[i]) p ^= gt[i];
        return {m, p};
    endfunction

    // handshake monitor: inputs settle at posedge+1, so negedge sees what the next edge accepts
    initial forever begin
        @(negedge clk);
        if (y_valid && y_ready && !reset) begin
            exp_t e;
            logic [0:9] s;
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %b expected no codeword", y_t);
            end else begin
                e = exp_q.pop_front();
                chk("codeword", 32'(y_t), 32'(e.cw));
                if (e.syn) begin
                    s = y_t[5:14];
                    for (int i = 0; i < 5; i++) if (y_t[i]) s ^= gt[i];
                    chk("syndrome", 32'(s), 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [0:4] m, input logic [0:14] mk, input logic [0:14] e, input bit push, input bit syn);
        int t = 0;
        while (!msg_ready && t < 50) begin
            step();
            t++;
        end
        chk("ready_timeout", 32'(msg_ready), 32'd1);
        msg = m;
        err_mask = mk;
        msg_valid = 1'b1;
        if (push) begin
            exp_q.push_back('{cw: e, syn: syn});
            n_exp++;
        end
        step();
        msg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || y_valid) && t < 100) begin
            step();
            t++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_latency();
        int lat = 0;
        chk("ready_low_after_accept", 32'(msg_ready), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        while (!y_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd5);
    endtask

    initial begin
        logic [0:14] held;
        bit          bad;
        step();
        step();
        chk("rst_msg_ready", 32'(msg_ready), 32'd1);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_t", 32'(y_t), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            step();
            bad |= y_valid;
        end
        chk("idle_no_valid", 32'(bad), 32'd0);

        send(5'b10000, '0, 15'b100001100100110, 1, 1);
        check_latency();
        wait_idle();
        chk("y_t_kept", 32'(y_t), 32'(15'b100001100100110));
        send(5'b00000, '0, 15'b0, 1, 1);
        check_latency();
        wait_idle();
        send(5'b11000, '0, 15'b110001010110101, 1, 1);
        wait_idle();
        send(5'b11111, '0, 15'b111111110101011, 1, 1);
        wait_idle();

        for (int m = 0; m < 32; m++) begin
            send(5'(m), '0, enc(5'(m)), 1, 1);
            wait_idle();
        end

        // mask and message are captured at acceptance; later changes must not leak in
        send(5'b00000, 15'b000000010000011, 15'b000000010000011, 1, 0);
        err_mask = '1;
        msg = '1;
        wait_idle();
        err_mask = '0;

        y_ready = 1'b0;
        send(5'b10000, '0, 15'b100001100100110, 1, 1);
        while (!y_valid) step();
        held = y_t;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            msg = 5'b11111;
            msg_valid = (i == 1);
            step();
            bad |= (y_t !== held) || !y_valid || msg_ready;
        end
        msg_valid = 1'b0;
        chk("stall_stable", 32'(bad), 32'd0);
        y_ready = 1'b1;
        wait_idle();
        repeat (10) step();
        chk("stall_no_extra", 32'(y_valid), 32'd0);

        send(5'b11111, '0, '0, 0, 0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_ready", 32'(msg_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        bad = y_valid;
        repeat (8) begin
            step();
            bad |= y_valid;
        end
        chk("midrst_no_output", 32'(bad), 32'd0);
        send(5'b01000, '0, 15'b010000110010011, 1, 1);
        wait_idle();

        repeat (3) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("output_count", 32'(n_out), 32'(n_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
